inv_mix_columns_serial: RTL and testbench
=========================================

Name: inv_mix_columns_serial

Overview:
Serialised inverse diffusion layer for the Blink-64a decryption datapath. It takes a 64-bit state over a valid/ready handshake and applies the inverse column mix, processing COLS_PER_CYCLE columns per clock through a shared column unit. The result is returned over a second valid/ready handshake. It sits between the inverse S-box layer and the round-key XOR in the area-optimised decrypt round.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  upstream has a state word on indata.
in_ready  output  1  block accepts indata this cycle.
indata  input  64  ciphertext-side state.
out_valid  output  1  outdata holds a finished result.
out_ready  input  1  downstream accepts outdata.
outdata  output  64  inverse-mixed state, driven directly from the state register.
busy  output  1  high while in BUSY.

Behaviour:
- Cell k occupies bits [4k+3:4k], k = 0..15. Column c (0..3) is cells {c, c+4, c+8, c+12}.
- Column transform: each output cell equals the XOR of the other three input cells of the same column. The matrix is involutory over GF(2)^4, so this is the exact inverse of the forward mix.
- Columns are independent. Cells are never moved between columns.
- N = 4/COLS_PER_CYCLE.
- State register st_q[63:0], column counter col_q[1:0], FSM {IDLE, BUSY, DONE}.
- Reset (async assert):
  - FSM goes to IDLE; st_q, col_q, out_valid and busy go to 0.
  - in_ready is forced to 0 while rst is high.
  - A block in flight is discarded, with no output.
- in_ready = !rst && (IDLE || (DONE && out_ready)).
- IDLE: on in_valid && in_ready, load st_q <= indata and col_q <= 0, then go to BUSY.
- BUSY:
  - Each cycle, replace columns col_q .. col_q+COLS_PER_CYCLE-1 of st_q with their transform, then add COLS_PER_CYCLE to col_q (mod 4).
  - After the group containing column 3, go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid = 1 and outdata = st_q.
  - Both are held stable until out_ready.
  - On out_ready with in_valid, accept the new word the same cycle and go to BUSY (back-to-back).
  - On out_ready without in_valid, go to IDLE.
- Latency: out_valid rises exactly N cycles after the accepting edge.
- Back-to-back throughput: one block per N+1 cycles.
- out_valid is registered and not combinational on any input.
- in_valid dropping or indata changing after acceptance has no effect.

Decomposition:
- Package blink_pkg holds:
  - CELL_W=4, N_CELLS=16, N_COLS=4;
  - the FSM state enum;
  - functions get_col(state, c) (16-bit column) and put_col(state, c, col).
- Sub-module inv_col_unit: combinational, 16-bit column in and out.
  - Instantiated COLS_PER_CYCLE times.
  - The column select is muxed by col_q.

Test Plan:
- 0x0000_0000_0000_000F with COLS_PER_CYCLE=1, out_ready=1 -> outdata 0x000F_000F_000F_0000; out_valid rises 4 cycles after acceptance.
- 0x0000_0000_0000_0021 -> 0x0021_0021_0021_0000. 0xFFFF_FFFF_FFFF_FFFF -> unchanged. 0x0123_4567_89AB_CDEF -> unchanged, because every column XORs to 0.
- Involution: feed outdata back as indata for 200 random words -> result equals the original word. Repeat for COLS_PER_CYCLE = 1, 2 and 4, with latencies 4, 2 and 1 respectively.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> outdata stable and in_ready=0. Then raise out_ready with in_valid=1 -> new word accepted the same cycle and the next result appears N cycles later.
- Reset: assert rst in the 2nd BUSY cycle -> out_valid=0, st_q=0 and in_ready=0 immediately (asynchronous). After release the block is in IDLE with in_ready=1 and emits no stale output.
- Stream of 8 words with random in_valid/out_ready -> outputs in order, none dropped or duplicated, matching the reference model.

Source files
------------

// File: rtl/inv_mix_columns_serial_pkg.sv
// Shared constants, FSM encoding and column gather/scatter helpers for the
// Blink-64a serialised inverse column mix.
package blink_pkg;

    localparam int CELL_W  = 4;
    localparam int N_CELLS = 16;
    localparam int N_COLS  = 4;
    localparam int N_ROWS  = N_CELLS / N_COLS;
    localparam int COL_W   = N_ROWS * CELL_W;
    localparam int STATE_W = N_CELLS * CELL_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    // Column c is cells {c, c+4, c+8, c+12}; row r lands in column bits [4r+3:4r].
    function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] st,
                                                 input logic [1:0]         c);
        logic [COL_W-1:0] col;
        col = '0;
        for (int row = 0; row < N_ROWS; row++) begin
            col[row*CELL_W +: CELL_W] = st[(int'(c) + N_COLS*row)*CELL_W +: CELL_W];
        end
        return col;
    endfunction

    function automatic logic [STATE_W-1:0] put_col(input logic [STATE_W-1:0] st,
                                                   input logic [1:0]         c,
                                                   input logic [COL_W-1:0]   col);
        logic [STATE_W-1:0] res;
        res = st;
        for (int row = 0; row < N_ROWS; row++) begin
            res[(int'(c) + N_COLS*row)*CELL_W +: CELL_W] = col[row*CELL_W +: CELL_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/inv_mix_columns_serial_inv_col_unit.sv
// Inverse mix of one 16-bit column: every output cell is the XOR of the
// other three input cells (the matrix is its own inverse).
module inv_col_unit
    import blink_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    output logic [COL_W-1:0] o_col
);

    logic [CELL_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int row = 0; row < N_ROWS; row++) begin
            w_sum = w_sum ^ i_col[row*CELL_W +: CELL_W];
        end
    end

    // Folding the cell back out of the full sum leaves the XOR of the others.
    always_comb begin
        for (int row = 0; row < N_ROWS; row++) begin
            o_col[row*CELL_W +: CELL_W] = w_sum ^ i_col[row*CELL_W +: CELL_W];
        end
    end

endmodule

// File: rtl/inv_mix_columns_serial.sv
// Serialised inverse column mix for the Blink-64a decrypt round: accepts a
// 64-bit state, mixes COLS_PER_CYCLE columns per clock, returns the result.
module inv_mix_columns_serial
    import blink_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] indata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] outdata,
    output logic               busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
            $error("inv_mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(N_COLS - COLS_PER_CYCLE);

    mix_state_t         r_state;
    logic [STATE_W-1:0] r_st;
    logic [1:0]         r_col;

    mix_state_t         w_state_nxt;
    logic [STATE_W-1:0] w_st_nxt;
    logic [1:0]         w_col_nxt;
    logic [STATE_W-1:0] w_st_mixed;
    logic               w_accept;

    logic [1:0]       w_col_idx [COLS_PER_CYCLE];
    logic [COL_W-1:0] w_col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] w_col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign w_col_idx[g] = r_col + 2'(g);
        assign w_col_in[g]  = get_col(r_st, w_col_idx[g]);

        inv_col_unit u_col (
            .i_col (w_col_in[g]),
            .o_col (w_col_out[g])
        );
    end

    always_comb begin
        w_st_mixed = r_st;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_st_mixed = put_col(w_st_mixed, w_col_idx[g], w_col_out[g]);
        end
    end

    assign in_ready  = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_BUSY);
    assign outdata   = r_st;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_st_nxt    = r_st;
        w_col_nxt   = r_col;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_st_nxt    = indata;
                    w_col_nxt   = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_st_nxt  = w_st_mixed;
                w_col_nxt = r_col + COL_STEP;
                if (r_col == LAST_COL) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_st_nxt    = indata;
                        w_col_nxt   = '0;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the state word is
    // reset as well, since it drives outdata directly and must not leak a discarded block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_st    <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_st    <= w_st_nxt;
            r_col   <= w_col_nxt;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_serial.sv
// Self-checking bench: three instances (1, 2 and 4 columns per cycle) checked
// against a cell-level reference model, vector table and handshake sequences.
module tb_inv_mix_columns_serial;

    logic        clk;
    logic        rst;
    logic        iv  [3];
    logic        ir  [3];
    logic [63:0] id  [3];
    logic        ov  [3];
    logic        ord [3];
    logic [63:0] od  [3];
    logic        bsy [3];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_serial #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .indata    (id[g]),
            .out_valid (ov[g]),
            .out_ready (ord[g]),
            .outdata   (od[g]),
            .busy      (bsy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs [4];

    // Reference: per column, each output cell = (XOR of all four cells) ^ itself.
    function automatic logic [63:0] ref_mix(input logic [63:0] x);
        logic [3:0]  cells [16];
        logic [3:0]  s;
        logic [63:0] y;
        for (int k = 0; k < 16; k++) cells[k] = x[4*k +: 4];
        y = '0;
        for (int c = 0; c < 4; c++) begin
            s = cells[c] ^ cells[c+4] ^ cells[c+8] ^ cells[c+12];
            for (int r = 0; r < 4; r++) y[4*(c+4*r) +: 4] = s ^ cells[c+4*r];
        end
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word through instance d with out_ready held high; returns result and latency.
    task automatic run_word(input int d, input logic [63:0] word,
                            output logic [63:0] res, output int lat);
        int w;
        iv[d]  = 1'b1;
        id[d]  = word;
        ord[d] = 1'b1;
        #1;
        w = 0;
        while (!ir[d] && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("accept_timeout", 64'(w), 64'd0);
        step();
        // Keep in_valid high with junk during BUSY: it must be ignored.
        id[d] = {$urandom, $urandom};
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ov[d] && lat < 20);
        res   = od[d];
        iv[d] = 1'b0;
    endtask

    initial begin
        logic [63:0] res, res2, x, held, wb;
        logic [63:0] words [8];
        logic [63:0] exp_q [$];
        int lat, sent, rcv, cyc, nlat;
        logic stable_ok, stale;
        logic hs_in, hs_out;

        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; id[d] = '0; ord[d] = 1'b0;
        end
        vecs[0] = '{din: 64'h0000_0000_0000_000F, dout: 64'h000F_000F_000F_0000};
        vecs[1] = '{din: 64'h0000_0000_0000_0021, dout: 64'h0021_0021_0021_0000};
        vecs[2] = '{din: 64'hFFFF_FFFF_FFFF_FFFF, dout: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{din: 64'h0123_4567_89AB_CDEF, dout: 64'h0123_4567_89AB_CDEF};

        rst = 1'b1;
        step();
        step();
        check("reset_out_valid", 64'(ov[0]), 64'd0);
        check("reset_outdata",   od[0],      64'd0);
        check("reset_in_ready",  64'(ir[0]), 64'd0);
        check("reset_busy",      64'(bsy[0]), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(ir[0]), 64'd1);

        // Vector table on every instance, latency N = 4 >> d.
        for (int d = 0; d < 3; d++) begin
            nlat = 4 >> d;
            for (int v = 0; v < 4; v++) begin
                run_word(d, vecs[v].din, res, lat);
                check($sformatf("vec%0d_cpc%0d", v, 1 << d), res, vecs[v].dout);
                check($sformatf("vec%0d_lat_cpc%0d", v, 1 << d), 64'(lat), 64'(nlat));
            end
        end

        // Involution with random words.
        for (int d = 0; d < 3; d++) begin
            nlat = 4 >> d;
            for (int i = 0; i < 200; i++) begin
                x = {$urandom, $urandom};
                run_word(d, x, res, lat);
                check($sformatf("rand_model_cpc%0d", 1 << d), res, ref_mix(x));
                check($sformatf("rand_lat_cpc%0d", 1 << d), 64'(lat), 64'(nlat));
                run_word(d, res, res2, lat);
                check($sformatf("involution_cpc%0d", 1 << d), res2, x);
            end
            step();
            step();
        end

        // Back-pressure on instance 0 then back-to-back acceptance.
        x  = 64'hDEAD_BEEF_0BAD_F00D;
        wb = 64'h1357_9BDF_2468_ACE0;
        iv[0] = 1'b1; id[0] = x; ord[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ov[0] && lat < 20);
        check("bp_latency", 64'(lat), 64'd4);
        held = od[0];
        check("bp_result", held, ref_mix(x));
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            id[0] = {$urandom, $urandom};
            iv[0] = 1'b1;
            #1;
            if (od[0] !== held || ov[0] !== 1'b1 || ir[0] !== 1'b0) stable_ok = 1'b0;
            iv[0] = 1'b0;
            step();
        end
        check("bp_hold_stable", 64'(stable_ok), 64'd1);
        iv[0] = 1'b1; id[0] = wb; ord[0] = 1'b1;
        #1;
        check("b2b_in_ready", 64'(ir[0]), 64'd1);
        step();
        iv[0] = 1'b0;
        check("b2b_busy", 64'(bsy[0]), 64'd1);
        check("b2b_out_valid_low", 64'(ov[0]), 64'd0);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ov[0] && lat < 20);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_result", od[0], ref_mix(wb));
        step();
        step();

        // Asynchronous reset during the second BUSY cycle.
        iv[0] = 1'b1; id[0] = 64'hA5A5_5A5A_C3C3_3C3C; ord[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(ov[0]), 64'd0);
        check("arst_outdata",   od[0],      64'd0);
        check("arst_in_ready",  64'(ir[0]), 64'd0);
        check("arst_busy",      64'(bsy[0]), 64'd0);
        check("arst_in_ready_cpc2", 64'(ir[1]), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(ir[0]), 64'd1);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ov[0] !== 1'b0) stale = 1'b1;
            step();
        end
        check("post_rst_no_stale", 64'(stale), 64'd0);

        // Random-handshake stream of 8 words per instance.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) words[i] = {$urandom, $urandom};
            exp_q.delete();
            sent = 0; rcv = 0; cyc = 0;
            while (rcv < 8 && cyc < 2000) begin
                iv[d]  = (sent < 8) && ($urandom_range(0, 1) == 1);
                id[d]  = (sent < 8) ? words[sent] : {$urandom, $urandom};
                ord[d] = ($urandom_range(0, 1) == 1);
                #1;
                hs_in  = iv[d] && ir[d];
                hs_out = ov[d] && ord[d];
                if (hs_out) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("stream_extra_cpc%0d", 1 << d), od[d], 64'd0 ^ ~od[d]);
                    end else begin
                        check($sformatf("stream_cpc%0d", 1 << d), od[d], exp_q.pop_front());
                    end
                    rcv++;
                end
                if (hs_in) begin
                    exp_q.push_back(ref_mix(words[sent]));
                    sent++;
                end
                step();
                cyc++;
            end
            iv[d] = 1'b0; ord[d] = 1'b1;
            check($sformatf("stream_count_cpc%0d", 1 << d), 64'(rcv), 64'd8);
            stale = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (ov[d] !== 1'b0) stale = 1'b1;
            end
            check($sformatf("stream_no_dup_cpc%0d", 1 << d), 64'(stale), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
